fir_coeff_loader: RTL

Upstream coefficient loader for the reconfigurable FIR filter. It accepts a tap count and a valid/ready stream of signed 16-bit coefficients. It then drives the filter's coefficient-update and RAM write port (update flag, chip select, write enable, bank address, data, coefficient index), zero-padding unused slots. Loading starts only on a 600 kHz sample strobe, so a reload never begins in the middle of a sample period.

---
 rtl/fir_coeff_loader.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the reconfigurable FIR: streams taps into the banked coefficient RAM and zero-pads unused slots.
// Optional build macro COEFF_SYM_EN: symmetric mode (odd tap count, half supplied, remainder mirrored from a buffer).
//
// state    | meaning
// IDLE     | waiting for iStart
// WAIT_SMP | tap count latched, waiting for the 600 kHz strobe
// FILL     | writing coefficients accepted from the source
// MIRROR   | writing the mirrored half from the buffer (COEFF_SYM_EN only)
// PAD      | writing zeros to the remaining slots
// DONE     | closing the update, one-cycle oDone
module fir_coeff_loader #(
  parameter int P_NUM_BANK   = 4,
  parameter int P_BANK_DEPTH = 10,
  parameter int P_MAX_TAP    = 33
) (
  input  logic        iClk_12M,
  input  logic        iRst,
  input  logic        iEnSample_600k,
  input  logic        iStart,
  input  logic [5:0]  iTapCnt,
  input  logic        iCoeffValid,
  input  logic [15:0] iCoeffData,
  output logic        oCoeffReady,
  output logic        oCoeffiUpdateFlag,
  output logic        oCsnRam,
  output logic        oWrnRam,
  output logic [3:0]  oAddrRam,
  output logic [15:0] oWrDtRam,
  output logic [5:0]  oNumOfCoeff,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);

  localparam logic [5:0] L_NUM_SLOT   = 6'(P_NUM_BANK * P_BANK_DEPTH);
  localparam logic [5:0] L_MAX_TAP    = 6'(P_MAX_TAP);
  localparam logic [3:0] L_BANK_DEPTH = 4'(P_BANK_DEPTH);

`ifdef COEFF_SYM_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT_SMP, S_FILL, S_MIRROR, S_PAD, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WAIT_SMP, S_FILL, S_PAD, S_DONE} state_t;
`endif

  state_t      state, stateNxt;
  logic [5:0]  tapLat, tapLatNxt;
  logic [5:0]  srcCnt, srcCntNxt;
  logic [5:0]  idx, idxNxt;
  logic [5:0]  accCnt, accCntNxt;
  logic [3:0]  slotAddr, slotAddrNxt;
  logic        readyNxt, flagNxt, csnNxt, wrnNxt, busyNxt, doneNxt, errNxt;
  logic [3:0]  addrNxt;
  logic [15:0] dataNxt;
  logic [5:0]  numNxt;

  logic        tapOk;
  logic [5:0]  srcLoad;
  logic        xfer;
  logic [5:0]  idxInc;
  logic [5:0]  accInc;
  logic [3:0]  addrInc;

  assign xfer    = iCoeffValid & oCoeffReady;
  assign idxInc  = idx + 6'd1;
  assign accInc  = accCnt + 6'd1;
  // slotAddr tracks (idx mod bank depth)+1 without a divider
  assign addrInc = (slotAddr == L_BANK_DEPTH) ? 4'd1 : slotAddr + 4'd1;

`ifdef COEFF_SYM_EN
  assign tapOk   = (iTapCnt != 6'd0) && (iTapCnt <= L_MAX_TAP) && iTapCnt[0];
  assign srcLoad = (iTapCnt + 6'd1) >> 1;

  logic [15:0] symBuf [0:16];
  logic [4:0]  mirIdx;
  assign mirIdx = 5'(tapLat - idxInc);

  always_ff @(posedge iClk_12M) begin
    if (state == S_FILL && xfer) symBuf[5'(idx)] <= iCoeffData;
  end
`else
  assign tapOk   = (iTapCnt != 6'd0) && (iTapCnt <= L_MAX_TAP);
  assign srcLoad = iTapCnt;
`endif

  always_comb begin
    stateNxt    = state;
    tapLatNxt   = tapLat;
    srcCntNxt   = srcCnt;
    idxNxt      = idx;
    accCntNxt   = accCnt;
    slotAddrNxt = slotAddr;
    readyNxt    = 1'b0;
    flagNxt     = oCoeffiUpdateFlag;
    csnNxt      = oCsnRam;
    wrnNxt      = 1'b1;
    addrNxt     = oAddrRam;
    dataNxt     = oWrDtRam;
    numNxt      = oNumOfCoeff;
    busyNxt     = oBusy;
    doneNxt     = 1'b0;
    errNxt      = 1'b0;

    case (state)
      S_IDLE: begin
        if (iStart) begin
          if (tapOk) begin
            tapLatNxt = iTapCnt;
            srcCntNxt = srcLoad;
            busyNxt   = 1'b1;
            stateNxt  = S_WAIT_SMP;
          end else begin
            errNxt = 1'b1;
          end
        end
      end

      S_WAIT_SMP: begin
        if (iEnSample_600k) begin
          stateNxt    = S_FILL;
          flagNxt     = 1'b1;
          csnNxt      = 1'b0;
          readyNxt    = 1'b1;
          idxNxt      = 6'd0;
          accCntNxt   = 6'd0;
          slotAddrNxt = 4'd1;
        end
      end

      S_FILL: begin
        readyNxt = oCoeffReady;
        if (xfer) begin
          wrnNxt      = 1'b0;
          addrNxt     = slotAddr;
          dataNxt     = iCoeffData;
          numNxt      = idx;
          idxNxt      = idxInc;
          slotAddrNxt = addrInc;
          accCntNxt   = accInc;
          readyNxt    = (accInc < srcCnt);
          if (idxInc == L_NUM_SLOT) begin
            readyNxt = 1'b0;
            stateNxt = S_DONE;
          end else if (accInc == srcCnt) begin
            readyNxt = 1'b0;
`ifdef COEFF_SYM_EN
            stateNxt = (srcCnt != tapLat) ? S_MIRROR : S_PAD;
`else
            stateNxt = S_PAD;
`endif
          end
        end
      end

`ifdef COEFF_SYM_EN
      S_MIRROR: begin
        wrnNxt      = 1'b0;
        addrNxt     = slotAddr;
        dataNxt     = symBuf[mirIdx];
        numNxt      = idx;
        idxNxt      = idxInc;
        slotAddrNxt = addrInc;
        if (idxInc == tapLat) stateNxt = (idxInc == L_NUM_SLOT) ? S_DONE : S_PAD;
      end
`endif

      S_PAD: begin
        wrnNxt      = 1'b0;
        addrNxt     = slotAddr;
        dataNxt     = 16'h0000;
        numNxt      = idx;
        idxNxt      = idxInc;
        slotAddrNxt = addrInc;
        if (idxInc == L_NUM_SLOT) stateNxt = S_DONE;
      end

      S_DONE: begin
        flagNxt  = 1'b0;
        csnNxt   = 1'b1;
        numNxt   = tapLat;
        doneNxt  = 1'b1;
        busyNxt  = 1'b0;
        stateNxt = S_IDLE;
      end

      default: stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state             <= S_IDLE;
      tapLat            <= 6'd0;
      srcCnt            <= 6'd0;
      idx               <= 6'd0;
      accCnt            <= 6'd0;
      slotAddr          <= 4'd0;
      oCoeffReady       <= 1'b0;
      oCoeffiUpdateFlag <= 1'b0;
      oCsnRam           <= 1'b1;
      oWrnRam           <= 1'b1;
      oAddrRam          <= 4'd0;
      oWrDtRam          <= 16'h0000;
      oNumOfCoeff       <= 6'd0;
      oBusy             <= 1'b0;
      oDone             <= 1'b0;
      oErr              <= 1'b0;
    end else begin
      state             <= stateNxt;
      tapLat            <= tapLatNxt;
      srcCnt            <= srcCntNxt;
      idx               <= idxNxt;
      accCnt            <= accCntNxt;
      slotAddr          <= slotAddrNxt;
      oCoeffReady       <= readyNxt;
      oCoeffiUpdateFlag <= flagNxt;
      oCsnRam           <= csnNxt;
      oWrnRam           <= wrnNxt;
      oAddrRam          <= addrNxt;
      oWrDtRam          <= dataNxt;
      oNumOfCoeff       <= numNxt;
      oBusy             <= busyNxt;
      oDone             <= doneNxt;
      oErr              <= errNxt;
    end
  end

endmodule
